matrix_stream_loader: RTL and testbench

// - Streaming front end for the matrix multipliers.
// - Accepts IEEE-754 single-precision words one per handshake: A (LxM) row-major first, then B (MxN) row-major.
// - Assembles them into the flattened buses used by the multipliers: A, B (row-major for the parallel

---
 rtl/matrix_stream_loader.sv | 144 ++++++++++++++
 tb/tb_matrix_stream_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// Streaming loader: gathers A (LxM) then B (MxN) float words into flat operand buses plus B transposed.
// Optional sticky NaN detection is enabled by defining MATRIX_LOADER_NAN_CHECK_EN.
module matrix_stream_loader #(
    parameter int L = 2,
    parameter int M = 2,
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*L*M-1:0]     A,
    output logic [32*M*N-1:0]     B,
    output logic [32*M*N-1:0]     B_T,
    output logic                  nan_seen
);

    localparam int A_WORDS = L * M;
    localparam int B_WORDS = M * N;
    localparam int CNT_MAX = (A_WORDS > B_WORDS) ? A_WORDS : B_WORDS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] FULL   = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               accept;
    logic               write_a, write_b;
    logic [A_WORDS-1:0] a_we;
    logic [B_WORDS-1:0] b_we;

    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg == FULL);
    // Abort outranks a simultaneous handshake: the word is neither stored nor counted.
    assign accept    = in_valid & in_ready & ~abort;
    assign write_a   = accept & (state_reg == LOAD_A);
    assign write_b   = accept & (state_reg == LOAD_B);

    genvar gi;
    generate
        for (gi = 0; gi < A_WORDS; gi++) begin : g_a_we
            assign a_we[gi] = write_a && (cnt_reg == CW'(gi));
        end
        for (gi = 0; gi < B_WORDS; gi++) begin : g_b_we
            assign b_we[gi] = write_b && (cnt_reg == CW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            LOAD_A: begin
                if (abort) begin
                    cnt_next = '0;
                end else if (accept) begin
                    if (cnt_reg == CW'(A_WORDS - 1)) begin
                        cnt_next   = '0;
                        state_next = LOAD_B;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (abort) begin
                    cnt_next   = '0;
                    state_next = LOAD_A;
                end else if (accept) begin
                    if (cnt_reg == CW'(B_WORDS - 1)) begin
                        cnt_next   = '0;
                        state_next = FULL;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_next = LOAD_A;
                end
            end
            default: begin
                state_next = LOAD_A;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD_A;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // B slot k*N+j lands in B_T slot j*M+k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A   <= '0;
            B   <= '0;
            B_T <= '0;
        end else begin
            for (int s = 0; s < A_WORDS; s++) begin
                if (a_we[s]) begin
                    A[s*32 +: 32] <= in_data;
                end
            end
            for (int s = 0; s < B_WORDS; s++) begin
                if (b_we[s]) begin
                    B[s*32 +: 32]                     <= in_data;
                    B_T[((s % N) * M + s / N)*32 +: 32] <= in_data;
                end
            end
        end
    end

`ifdef MATRIX_LOADER_NAN_CHECK_EN
    logic is_nan;
    assign is_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_seen <= 1'b0;
        end else if (accept && is_nan) begin
            nan_seen <= 1'b1;
        end else if (out_valid && out_ready) begin
            nan_seen <= 1'b0;
        end
    end
`else
    assign nan_seen = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader (L=M=N=2): table-driven loads with a scoreboard queue of expected operand sets,
// plus hand-written hold, abort, reset and NaN sequences.
module tb_matrix_stream_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] A;
    logic [127:0] B;
    logic [127:0] B_T;
    logic         nan_seen;

    always #5 clk = ~clk;

    matrix_stream_loader #(.L(2), .M(2), .N(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .B_T(B_T), .nan_seen(nan_seen)
    );

`ifdef MATRIX_LOADER_NAN_CHECK_EN
    localparam logic NAN_EXP = 1'b1;
`else
    localparam logic NAN_EXP = 1'b0;
`endif

    typedef struct {
        logic [255:0] words;
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] ebt;
        int           gap;
    } vec_t;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] bt;
    } set_t;

    vec_t vecs[4];
    set_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent transpose model, used only for sets built on the fly.
    function automatic set_t model(input logic [255:0] w);
        set_t s;
        s.a = w[127:0];
        s.b = w[255:128];
        s.bt = '0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++)
                s.bt[(j*2+k)*32 +: 32] = w[128 + (k*2+j)*32 +: 32];
        return s;
    endfunction

    task automatic push_expect(input logic [127:0] ea, input logic [127:0] eb, input logic [127:0] ebt);
        set_t s;
        s.a = ea; s.b = eb; s.bt = ebt;
        sb_q.push_back(s);
    endtask

    task automatic send_word(input logic [31:0] w);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_set(input logic [255:0] words, input int gap, input string tag);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 3; g++)
                if ($urandom_range(99) < gap) tick();
            if (i == 7) check({tag, "_valid_before_last"}, 128'(out_valid), 128'd0);
            send_word(words[i*32 +: 32]);
        end
        check({tag, "_valid_after_last"}, 128'(out_valid), 128'd1);
    endtask

    task automatic wait_handoff(input string tag);
        int   guard = 0;
        set_t s;
        @(negedge clk);
        while (!(out_valid && out_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!(out_valid && out_ready)) begin
            total++;
            bad++;
            $display("FAIL %s_handoff_timeout: out_valid got %0b expected 1", tag, out_valid);
        end else if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_scoreboard_empty: got 0 entries expected 1", tag);
        end else begin
            s = sb_q.pop_front();
            check({tag, "_A"}, A, s.a);
            check({tag, "_B"}, B, s.b);
            check({tag, "_B_T"}, B_T, s.bt);
            $display("handoff %s: A=%h B=%h B_T=%h", tag, A, B, B_T);
        end
        tick();
    endtask

    initial begin
        logic [255:0] w;
        set_t s;

        vecs[0].words = 256'h40CCCCCC_C0CCCCCC_3F028F5C_40866666_BF000000_BF000000_3F28F5C2_404CCCCC;
        vecs[0].ea    = 128'hBF000000_BF000000_3F28F5C2_404CCCCC;
        vecs[0].eb    = 128'h40CCCCCC_C0CCCCCC_3F028F5C_40866666;
        vecs[0].ebt   = 128'h40CCCCCC_3F028F5C_C0CCCCCC_40866666;
        vecs[0].gap   = 0;
        vecs[1]       = vecs[0];
        vecs[1].gap   = 50;
        vecs[2].words = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
        vecs[2].ea    = 128'h00000004_00000003_00000002_00000001;
        vecs[2].eb    = 128'h00000008_00000007_00000006_00000005;
        vecs[2].ebt   = 128'h00000008_00000006_00000007_00000005;
        vecs[2].gap   = 0;
        vecs[3].words = 256'h0F0F0F0F_CAFEBABE_12345678_DEADBEEF_00000000_7F800000_80000000_FFFFFFFF;
        vecs[3].ea    = 128'h00000000_7F800000_80000000_FFFFFFFF;
        vecs[3].eb    = 128'h0F0F0F0F_CAFEBABE_12345678_DEADBEEF;
        vecs[3].ebt   = 128'h0F0F0F0F_12345678_CAFEBABE_DEADBEEF;
        vecs[3].gap   = 30;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_A", A, 128'd0);
        check("rst_B", B, 128'd0);
        check("rst_B_T", B_T, 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_nan_seen", 128'(nan_seen), 128'd0);
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'd1);

        for (int r = 0; r < 4; r++) begin
            push_expect(vecs[r].ea, vecs[r].eb, vecs[r].ebt);
            send_set(vecs[r].words, vecs[r].gap, $sformatf("vec%0d", r));
            if (r == 3) check("vec3_nan_seen", 128'(nan_seen), 128'(NAN_EXP));
            wait_handoff($sformatf("vec%0d", r));
        end
        check("after_handoff_nan_clear", 128'(nan_seen), 128'd0);

        // Hold the completed set while the producer keeps offering a word.
        out_ready = 1'b0;
        push_expect(vecs[0].ea, vecs[0].eb, vecs[0].ebt);
        send_set(vecs[0].words, 0, "hold");
        in_valid = 1'b1;
        in_data  = 32'h55555555;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_in_ready", 128'(in_ready), 128'd0);
            check("hold_out_valid", 128'(out_valid), 128'd1);
            check("hold_A", A, vecs[0].ea);
            check("hold_B_T", B_T, vecs[0].ebt);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_handoff("hold");
        check("hold_release_in_ready", 128'(in_ready), 128'd1);
        check("hold_release_out_valid", 128'(out_valid), 128'd0);
        push_expect(vecs[2].ea, vecs[2].eb, vecs[2].ebt);
        send_set(vecs[2].words, 0, "overwrite");
        wait_handoff("overwrite");

        // Abort after three A words, then a clean load.
        for (int i = 0; i < 3; i++) send_word(32'hA0000000 + 32'(i));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        push_expect(vecs[0].ea, vecs[0].eb, vecs[0].ebt);
        send_set(vecs[0].words, 0, "abort3");
        wait_handoff("abort3");

        // Abort inside LOAD_B coincident with an offered word.
        for (int i = 0; i < 5; i++) send_word(32'hB0000000 + 32'(i));
        in_valid = 1'b1;
        in_data  = 32'hDEAD0000;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_coincident_in_ready", 128'(in_ready), 128'd1);
        push_expect(vecs[2].ea, vecs[2].eb, vecs[2].ebt);
        send_set(vecs[2].words, 0, "abort_acc");
        wait_handoff("abort_acc");

        // Asynchronous reset in the middle of a load.
        for (int i = 0; i < 5; i++) send_word(vecs[0].words[i*32 +: 32]);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_A", A, 128'd0);
        check("midrst_B", B, 128'd0);
        check("midrst_B_T", B_T, 128'd0);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        tick();
        rst = 1'b0;
        push_expect(vecs[3].ea, vecs[3].eb, vecs[3].ebt);
        send_set(vecs[3].words, 0, "postrst");
        wait_handoff("postrst");

`ifdef MATRIX_LOADER_NAN_CHECK_EN
        w = vecs[2].words;
        w[2*32 +: 32] = 32'h7FC00000;
        s = model(w);
        push_expect(s.a, s.b, s.bt);
        send_word(w[31:0]);
        send_word(w[63:32]);
        check("nan_before", 128'(nan_seen), 128'd0);
        send_word(w[95:64]);
        check("nan_set", 128'(nan_seen), 128'd1);
        for (int i = 3; i < 8; i++) send_word(w[i*32 +: 32]);
        check("nan_sticky_full", 128'(nan_seen), 128'd1);
        wait_handoff("nan");
        check("nan_cleared", 128'(nan_seen), 128'd0);

        w[2*32 +: 32] = 32'h7F800000;
        s = model(w);
        push_expect(s.a, s.b, s.bt);
        send_set(w, 0, "inf");
        check("inf_no_nan", 128'(nan_seen), 128'd0);
        wait_handoff("inf");
`else
        w = '0;
        s = model(w);
        check("model_zero_bt", s.bt, B_T & 128'd0);
`endif

        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time got %0t expected below 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
